// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with a registered result and registered flags.
// Most opcodes finish after one EXEC cycle. MUL runs a WIDTH-cycle
// shift-add loop.
//
// Ports
//   clk      single clock, rising edge
//   rst_clk  synchronous active-low reset
//   ena      block enable; no new operation is accepted while low
//   start    requests a new operation (accepted when ena=1 and busy=0)
//   optcode  5-bit operation code, captured on acceptance
//   accmu    accumulator operand, captured on acceptance
//   data     data operand, captured on acceptance
//   busy     high from acceptance through the cycle in which done is high
//   done     one-cycle pulse when alu_out and the flags are updated
//   alu_out  registered result
//   zero, carry, ovf, neg, err  registered flags
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; also the cycle in which done is presented
// EXEC  | one cycle for single-cycle opcodes, then write result
// MUL   | shift-add loop, one multiplier bit per cycle, WIDTH cycles
module alu_mc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_clk,
  input  logic             ena,
  input  logic             start,
  input  logic [4:0]       optcode,
  input  logic [WIDTH-1:0] accmu,
  input  logic [WIDTH-1:0] data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic             neg,
  output logic             err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_MUL  = 2'd2;

  localparam logic [4:0] OP_ADD = 5'b00001;
  localparam logic [4:0] OP_SUB = 5'b00010;
  localparam logic [4:0] OP_AND = 5'b00011;
  localparam logic [4:0] OP_OR  = 5'b00100;
  localparam logic [4:0] OP_LDA = 5'b00101;
  localparam logic [4:0] OP_STO = 5'b00110;
  localparam logic [4:0] OP_JMP = 5'b00111;
  localparam logic [4:0] OP_XOR = 5'b01000;
  localparam logic [4:0] OP_SHL = 5'b01001;
  localparam logic [4:0] OP_SHR = 5'b01010;
  localparam logic [4:0] OP_MUL = 5'b01011;

  localparam int CW = $clog2(WIDTH);

  logic [1:0]       state;
  logic [4:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic [WIDTH:0]   add_ext;
  logic [WIDTH:0]   sub_ext;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_nx;
  logic [WIDTH-1:0] mul_lo_nx;

  logic [WIDTH-1:0] ex_res;
  logic             ex_carry;
  logic             ex_ovf;
  logic             ex_err;

  // busy also covers the done cycle, so acceptance cannot overlap it
  assign accept = ena && start && !busy;

  // The MSB of sub_ext is the borrow (data < accmu unsigned)
  assign add_ext = {1'b0, d_q} + {1'b0, a_q};
  assign sub_ext = {1'b0, d_q} - {1'b0, a_q};

  // One shift-add step. The product is held as {hi_q, lo_q}. Multiplier
  // bits leave lo_q from the bottom while product bits enter from the top.
  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
  assign mul_hi_nx = mul_sum[WIDTH:1];
  assign mul_lo_nx = {mul_sum[0], lo_q[WIDTH-1:1]};

  always_comb begin
    ex_res   = '0;
    ex_carry = 1'b0;
    ex_ovf   = 1'b0;
    ex_err   = 1'b0;
    case (op_q)
      OP_ADD: begin
        ex_res   = add_ext[WIDTH-1:0];
        ex_carry = add_ext[WIDTH];
        ex_ovf   = (d_q[WIDTH-1] == a_q[WIDTH-1]) &&
                   (add_ext[WIDTH-1] != d_q[WIDTH-1]);
      end
      OP_SUB: begin
        ex_res   = sub_ext[WIDTH-1:0];
        ex_carry = sub_ext[WIDTH];
        ex_ovf   = (d_q[WIDTH-1] != a_q[WIDTH-1]) &&
                   (sub_ext[WIDTH-1] != d_q[WIDTH-1]);
      end
      OP_AND: ex_res = d_q & a_q;
      OP_OR:  ex_res = d_q | a_q;
      OP_LDA: ex_res = d_q;
      OP_STO: ex_res = a_q;
      OP_JMP: ex_res = a_q;
      OP_XOR: ex_res = d_q ^ a_q;
      OP_SHL: begin
        ex_res   = a_q << 1;
        ex_carry = a_q[WIDTH-1];
      end
      OP_SHR: begin
        ex_res   = a_q >> 1;
        ex_carry = a_q[0];
      end
      default: ex_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_clk) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      alu_out <= '0;
      zero    <= 1'b1;
      carry   <= 1'b0;
      ovf     <= 1'b0;
      neg     <= 1'b0;
      err     <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      d_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          busy <= accept;
          if (accept) begin
            op_q  <= optcode;
            a_q   <= accmu;
            d_q   <= data;
            hi_q  <= '0;
            lo_q  <= data;
            cnt   <= CW'(WIDTH - 1);
            state <= (optcode == OP_MUL) ? ST_MUL : ST_EXEC;
          end
        end
        ST_EXEC: begin
          alu_out <= ex_res;
          zero    <= (ex_res == '0);
          neg     <= ex_res[WIDTH-1];
          carry   <= ex_carry;
          ovf     <= ex_ovf;
          err     <= ex_err;
          done    <= 1'b1;
          state   <= ST_IDLE;
        end
        ST_MUL: begin
          hi_q <= mul_hi_nx;
          lo_q <= mul_lo_nx;
          if (cnt == '0) begin
            // Last step: the result comes straight from this step's values
            alu_out <= mul_lo_nx;
            zero    <= (mul_lo_nx == '0);
            neg     <= mul_lo_nx[WIDTH-1];
            carry   <= |mul_hi_nx;
            ovf     <= 1'b0;
            err     <= 1'b0;
            done    <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc (WIDTH=8).
// A latency/arithmetic model follows the DUT and is compared every cycle.
// Directed runs add literal checks that pin the model itself.
module tb_alu_mc;

  localparam int WIDTH = 8;
  localparam logic [4:0] OP_ADD = 5'b00001;
  localparam logic [4:0] OP_SUB = 5'b00010;
  localparam logic [4:0] OP_AND = 5'b00011;
  localparam logic [4:0] OP_OR  = 5'b00100;
  localparam logic [4:0] OP_LDA = 5'b00101;
  localparam logic [4:0] OP_STO = 5'b00110;
  localparam logic [4:0] OP_JMP = 5'b00111;
  localparam logic [4:0] OP_XOR = 5'b01000;
  localparam logic [4:0] OP_SHL = 5'b01001;
  localparam logic [4:0] OP_SHR = 5'b01010;
  localparam logic [4:0] OP_MUL = 5'b01011;

  logic             clk;
  logic             rst_clk;
  logic             ena;
  logic             start;
  logic [4:0]       optcode;
  logic [WIDTH-1:0] accmu;
  logic [WIDTH-1:0] data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] alu_out;
  logic             zero;
  logic             carry;
  logic             ovf;
  logic             neg;
  logic             err;

  alu_mc #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_clk(rst_clk), .ena(ena), .start(start),
    .optcode(optcode), .accmu(accmu), .data(data),
    .busy(busy), .done(done), .alu_out(alu_out),
    .zero(zero), .carry(carry), .ovf(ovf), .neg(neg), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference arithmetic with plain integers
  function automatic void ref_op(input logic [4:0] op, input int a, input int d,
                                 output int r, output bit c, output bit v, output bit e);
    int m, sa, sd, s, full;
    m  = 1 << WIDTH;
    sa = (a >= m/2) ? a - m : a;
    sd = (d >= m/2) ? d - m : d;
    r = 0; c = 0; v = 0; e = 0;
    case (op)
      OP_ADD: begin
        full = d + a; r = full % m; c = (full >= m);
        s = sd + sa; v = (s > m/2 - 1) || (s < -(m/2));
      end
      OP_SUB: begin
        full = d - a; r = (full + m) % m; c = (d < a);
        s = sd - sa; v = (s > m/2 - 1) || (s < -(m/2));
      end
      OP_AND: r = d & a;
      OP_OR:  r = d | a;
      OP_LDA: r = d;
      OP_STO: r = a;
      OP_JMP: r = a;
      OP_XOR: r = d ^ a;
      OP_SHL: begin r = (a * 2) % m; c = (a >= m/2); end
      OP_SHR: begin r = a / 2; c = (a % 2) == 1; end
      OP_MUL: begin full = a * d; r = full % m; c = (full >= m); end
      default: e = 1;
    endcase
  endfunction

  // Model: accepted op completes WIDTH edges later (MUL) or 1 edge later
  int m_rem = 0;
  bit m_busy = 0, m_done = 0;
  int m_out = 0;
  bit m_zero = 1, m_carry = 0, m_ovf = 0, m_neg = 0, m_err = 0;
  int p_out;
  bit p_c, p_v, p_e;
  bit acc;

  always @(posedge clk) begin
    if (!rst_clk) begin
      m_rem = 0; m_busy = 0; m_done = 0; m_out = 0;
      m_zero = 1; m_carry = 0; m_ovf = 0; m_neg = 0; m_err = 0;
    end else begin
      acc = ena && start && !m_busy;
      m_done = 0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_out = p_out; m_zero = (p_out == 0); m_neg = (p_out >= (1 << (WIDTH-1)));
          m_carry = p_c; m_ovf = p_v; m_err = p_e; m_done = 1;
        end
      end else if (acc) begin
        ref_op(optcode, int'(accmu), int'(data), p_out, p_c, p_v, p_e);
        m_rem = (optcode == OP_MUL) ? WIDTH : 1;
      end
      m_busy = (m_rem > 0) || m_done;
    end
    #1;
    check("busy", busy, m_busy);
    check("done", done, m_done);
    check("alu_out", alu_out, m_out);
    check("zero", zero, m_zero);
    check("carry", carry, m_carry);
    check("ovf", ovf, m_ovf);
    check("neg", neg, m_neg);
    check("err", err, m_err);
  end

  int lat, bc, dc;
  logic [WIDTH-1:0] snap_out;
  logic snap_zero;

  // Edge 1 is the acceptance edge. Optional second start at s2_edge and
  // reset at rst_edge. Operands are scrambled after acceptance.
  task automatic run_op(input logic [4:0] op, input logic [7:0] a, input logic [7:0] d,
                        input int s2_edge, input logic [4:0] op2, input logic [7:0] a2,
                        input logic [7:0] d2, input int rst_edge);
    @(negedge clk);
    ena = 1; start = 1; optcode = op; accmu = a; data = d;
    lat = 0; bc = 0; dc = 0;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #2;
      if (busy) bc++;
      if (done) begin dc++; if (lat == 0) lat = k; end
      if (k == rst_edge) begin snap_out = alu_out; snap_zero = zero; end
      start   = (k + 1 == s2_edge);
      rst_clk = !(k + 1 == rst_edge);
      if (k + 1 == s2_edge) begin
        optcode = op2; accmu = a2; data = d2;
      end else begin
        optcode = op ^ 5'h1F; accmu = a ^ 8'h55; data = d ^ 8'hAA;
      end
    end
  endtask

  task automatic go(input logic [4:0] op, input logic [7:0] a, input logic [7:0] d);
    run_op(op, a, d, 0, 5'b0, 8'h0, 8'h0, 0);
  endtask

  initial begin
    rst_clk = 0; ena = 0; start = 0; optcode = 0; accmu = 0; data = 0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out", alu_out, 8'h00);
    check("rst_zero", zero, 1);
    check("rst_err", err, 0);
    @(negedge clk);
    rst_clk = 1;

    go(OP_ADD, 8'h20, 8'hF0);
    check("add1_lat", lat, 2);
    check("add1_dc", dc, 1);
    check("add1_out", alu_out, 8'h10);
    check("add1_carry", carry, 1);
    check("add1_ovf", ovf, 0);

    go(OP_ADD, 8'h01, 8'h7F);
    check("add2_out", alu_out, 8'h80);
    check("add2_ovf", ovf, 1);
    check("add2_neg", neg, 1);

    go(OP_SUB, 8'h05, 8'h05);
    check("sub1_out", alu_out, 8'h00);
    check("sub1_zero", zero, 1);
    check("sub1_carry", carry, 0);

    go(OP_SUB, 8'h05, 8'h03);
    check("sub2_out", alu_out, 8'hFE);
    check("sub2_carry", carry, 1);
    check("sub2_neg", neg, 1);

    go(OP_MUL, 8'h0F, 8'h11);
    check("mul1_out", alu_out, 8'hFF);
    check("mul1_carry", carry, 0);
    check("mul1_busy_cycles", bc, 9);
    check("mul1_lat", lat, 9);

    go(OP_MUL, 8'h10, 8'h10);
    check("mul2_out", alu_out, 8'h00);
    check("mul2_carry", carry, 1);
    check("mul2_zero", zero, 1);

    run_op(OP_MUL, 8'h0D, 8'h0B, 3, OP_ADD, 8'h03, 8'h07, 0);
    check("mul3_out", alu_out, 8'h8F);
    check("mul3_lat", lat, 9);
    check("mul3_dc", dc, 1);

    @(negedge clk);
    ena = 0; start = 1; optcode = OP_ADD; accmu = 8'h01; data = 8'h01;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #2;
      check("ena0_busy", busy, 0);
    end
    start = 0; ena = 1;

    run_op(OP_MUL, 8'h21, 8'h13, 5, OP_ADD, 8'h01, 8'h01, 4);
    check("rst_mid_out", snap_out, 8'h00);
    check("rst_mid_zero", snap_zero, 1);
    check("rst_add_lat", lat, 6);
    check("rst_add_dc", dc, 1);
    check("rst_add_out", alu_out, 8'h02);

    go(5'b11111, 8'h12, 8'h34);
    check("bad_out", alu_out, 8'h00);
    check("bad_err", err, 1);
    check("bad_zero", zero, 1);

    go(OP_LDA, 8'h00, 8'hA5);
    check("lda_out", alu_out, 8'hA5);
    check("lda_err", err, 0);
    check("lda_neg", neg, 1);

    go(OP_SHL, 8'h81, 8'h00);
    check("shl_out", alu_out, 8'h02);
    check("shl_carry", carry, 1);
    go(OP_SHR, 8'h81, 8'h00);
    check("shr_out", alu_out, 8'h40);
    check("shr_carry", carry, 1);
    go(OP_XOR, 8'h0F, 8'hAA);
    check("xor_out", alu_out, 8'hA5);
    go(OP_AND, 8'h3C, 8'hF0);
    go(OP_OR,  8'h3C, 8'h03);
    go(OP_STO, 8'h9A, 8'h11);
    go(OP_JMP, 8'h00, 8'h77);
    go(5'b00000, 8'h44, 8'h55);
    go(OP_MUL, 8'hFF, 8'hFF);
    check("mul4_out", alu_out, 8'h01);

    repeat (3) @(posedge clk);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH SHALL default to 8 and set the operand and result width in bits; legal values are 4..32.
REQ-002 Port clk SHALL be an input, 1 bit wide, and serve as the single clock; all state updates on its rising edge.
REQ-003 Port rst_clk SHALL be an input, 1 bit wide, and act as a synchronous, active-low reset.
REQ-004 Port ena SHALL be an input, 1 bit wide, and act as the block enable; when low, no new operation is accepted.
REQ-005 Port start SHALL be an input, 1 bit wide, and request a new operation.
REQ-006 Port optcode SHALL be an input, 5 bits wide, and carry the operation code.
REQ-007 Port accmu SHALL be an input, WIDTH bits wide, and carry the accumulator operand.
REQ-008 Port data SHALL be an input, WIDTH bits wide, and carry the data operand.
REQ-009 Port busy SHALL be an output, 1 bit wide, high while an accepted operation is in progress.
REQ-010 Port done SHALL be an output, 1 bit wide, and pulse for exactly one cycle when the result is valid.
REQ-011 Port alu_out SHALL be an output, WIDTH bits wide, and carry the registered result.
REQ-012 Flag outputs zero, carry, ovf, neg and err SHALL each be 1 bit wide and registered.

Function
REQ-013 An operation SHALL be accepted on a rising edge where rst_clk=1, ena=1, start=1 and busy=0; optcode, accmu and data are captured on that edge.
REQ-014 start SHALL be ignored while busy=1 or ena=0, with no effect on state or outputs.
REQ-015 The state machine SHALL have states IDLE, EXEC and MUL; acceptance moves IDLE->EXEC for single-cycle codes and IDLE->MUL for MUL.
REQ-016 EXEC SHALL last one cycle, then write alu_out and the flags, pulse done and return to IDLE; done is high on the 2nd edge after acceptance.
REQ-017 MUL SHALL run a shift-add loop for exactly WIDTH cycles, then write results, pulse done and return to IDLE; done is high on edge WIDTH+1 after acceptance.
REQ-018 busy SHALL be high from the edge after acceptance through the edge on which done rises, and low in IDLE.
REQ-019 The opcodes SHALL be: ADD 00001 = data+accmu; SUB 00010 = data-accmu; AND 00011; OR 00100; LDA 00101 = data; STO 00110 = accmu; JMP 00111 = accmu; XOR 01000.
REQ-020 The extended opcodes SHALL be: SHL 01001 = accmu<<1; SHR 01010 = accmu>>1 (logical); MUL 01011 = low WIDTH bits of unsigned accmu*data.
REQ-021 carry SHALL reflect, per opcode: ADD = carry-out; SUB = borrow (data<accmu unsigned); SHL = accmu[WIDTH-1]; SHR = accmu[0]; MUL = 1 if the upper WIDTH product bits are nonzero; all other opcodes = 0.
REQ-022 ovf SHALL be the two's-complement signed overflow of ADD/SUB and 0 for every other opcode.
REQ-023 zero SHALL be 1 iff the new alu_out is all zeros; neg SHALL equal the new alu_out[WIDTH-1].
REQ-024 Any unlisted opcode (including 00000) SHALL take the EXEC path, produce alu_out=0, zero=1, err=1 and carry=ovf=neg=0; every valid opcode clears err.
REQ-025 alu_out and all flags SHALL hold their values between done pulses; they do not change on acceptance or during MUL.
REQ-026 Operands SHALL be used only as captured; input changes after acceptance do not affect the result.
REQ-027 Arithmetic SHALL be modulo 2^WIDTH, with no sign extension into alu_out.

Reset
REQ-028 With rst_clk=0 at a rising edge, the block SHALL enter IDLE with busy=0, done=0, alu_out=0, zero=1 and carry=ovf=neg=err=0.
REQ-029 Reset asserted mid-EXEC or mid-MUL SHALL abort the operation with no done pulse; the first operation can be accepted on the first edge with rst_clk=1.
REQ-030 Reset SHALL take priority over a simultaneous start.

Verification (WIDTH=8)
REQ-031 ADD with data=0xF0, accmu=0x20 SHALL give alu_out=0x10, carry=1, ovf=0, done at edge 2; ADD with 0x7F+0x01 SHALL give 0x80, ovf=1, neg=1.
REQ-032 SUB with data=0x05, accmu=0x05 SHALL give 0x00, zero=1, carry=0; SUB with data=0x03, accmu=0x05 SHALL give 0xFE, carry=1, neg=1.
REQ-033 MUL 0x0F*0x11 SHALL give 0xFF, carry=0, busy high for 9 cycles, done at edge 9; MUL 0x10*0x10 SHALL give 0x00, carry=1, zero=1.
REQ-034 A start pulse at edge 3 of a MUL with different operands SHALL be ignored and the original product delivered; a start with ena=0 in IDLE SHALL leave busy=0.
REQ-035 Reset at edge 4 of a MUL SHALL produce no done pulse, alu_out=0, zero=1, and a following ADD 0x01+0x01 SHALL complete with 0x02.
REQ-036 Opcode 11111 SHALL give alu_out=0 and err=1; a following LDA data=0xA5 SHALL give 0xA5, err=0, neg=1.
